// File: rtl/fft_pkg.sv
// fft_pkg: shared types, FSM states and constant helpers for the radix-2 FFT core.
package fft_pkg;
    localparam int SAMPLE_W  = 16;
    localparam int TWIDDLE_W = 16;

    typedef logic signed [SAMPLE_W-1:0]  sample_t;
    typedef logic signed [TWIDDLE_W-1:0] twiddle_t;
    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DONE} state_t;

    function automatic int bitrev(int v, int bits);
        int r;
        r = 0;
        for (int i = 0; i < bits; i++) r = (r << 1) | ((v >> i) & 1);
        return r;
    endfunction

    // Q1.(tw-1) twiddle entry, rounded to nearest; +1.0 clamps to the largest code.
    function automatic int twiddle(int k, int n, int tw, bit is_sin);
        real a, v;
        int  r, top;
        a   = 2.0 * 3.141592653589793 * real'(k) / real'(n);
        v   = (is_sin ? $sin(a) : $cos(a)) * real'(longint'(1) << (tw - 1));
        r   = $rtoi(v >= 0.0 ? v + 0.5 : v - 0.5);
        top = (1 << (tw - 1)) - 1;
        return r > top ? top : r;
    endfunction

    function automatic longint rnd(longint v, int tw);
        return (v + (longint'(1) << (tw - 2))) >>> (tw - 1);
    endfunction

    function automatic longint sat(longint v, int dw);
        longint hi;
        hi = (longint'(1) << (dw - 1)) - 1;
        return v > hi ? hi : (v < -hi - 1 ? -hi - 1 : v);
    endfunction
endpackage

// File: rtl/fft_butterfly.sv
// fft_butterfly: combinational DIT butterfly a' = a + b*W, b' = a - b*W with scaling or saturation.
module fft_butterfly
    import fft_pkg::*;
#(
    parameter int DW       = 16,
    parameter int TW       = 16,
    parameter int SCALE_EN = 1
) (
    input  logic signed [DW-1:0] a_re,
    input  logic signed [DW-1:0] a_im,
    input  logic signed [DW-1:0] b_re,
    input  logic signed [DW-1:0] b_im,
    input  logic signed [TW-1:0] w_cos,
    input  logic signed [TW-1:0] w_sin,
    input  logic                 inverse,
    output logic signed [DW-1:0] x_re,
    output logic signed [DW-1:0] x_im,
    output logic signed [DW-1:0] y_re,
    output logic signed [DW-1:0] y_im,
    output logic                 ovf
);
    longint w_im, t_re, t_im, s_xr, s_xi, s_yr, s_yi;

    function automatic longint scl(longint v);
        return SCALE_EN != 0 ? v >>> 1 : v;
    endfunction

    always_comb begin
        w_im = inverse ? longint'(w_sin) : -longint'(w_sin);
        t_re = rnd(longint'(b_re) * longint'(w_cos) - longint'(b_im) * w_im, TW);
        t_im = rnd(longint'(b_re) * w_im + longint'(b_im) * longint'(w_cos), TW);
        s_xr = scl(longint'(a_re) + t_re);
        s_xi = scl(longint'(a_im) + t_im);
        s_yr = scl(longint'(a_re) - t_re);
        s_yi = scl(longint'(a_im) - t_im);
        x_re = DW'(sat(s_xr, DW));
        x_im = DW'(sat(s_xi, DW));
        y_re = DW'(sat(s_yr, DW));
        y_im = DW'(sat(s_yi, DW));
        ovf  = sat(s_xr, DW) != s_xr || sat(s_xi, DW) != s_xi ||
               sat(s_yr, DW) != s_yr || sat(s_yi, DW) != s_yi;
    end
endmodule

// File: rtl/fft_radix2_param.sv
// fft_radix2_param: iterative radix-2 DIT FFT/IFFT, one butterfly per cycle over a register array.
module fft_radix2_param
    import fft_pkg::*;
#(
    parameter int N        = 64,
    parameter int LOG2N    = 6,
    parameter int DW       = $bits(sample_t),
    parameter int TW       = $bits(twiddle_t),
    parameter int SCALE_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] input_Re  [N-1:0],
    input  logic signed [DW-1:0] input_Im  [N-1:0],
    input  logic                 start,
    input  logic                 inverse,
    output logic signed [DW-1:0] output_Re [N-1:0],
    output logic signed [DW-1:0] output_Im [N-1:0],
    output logic                 busy,
    output logic                 done,
    output logic                 overflow
);
    localparam int               KW    = LOG2N - 1;
    localparam logic [LOG2N-1:0] SMAX  = LOG2N'(LOG2N - 1);
    localparam logic [LOG2N-1:0] BLAST = LOG2N'(N / 2 - 1);

    state_t               state_q, state_d;
    logic [LOG2N-1:0]     stage_q, stage_d, bfly_q, bfly_d;
    logic                 inv_q, inv_d, ovf_q, ovf_d, done_q, done_d;
    logic signed [DW-1:0] work_re_q [N-1:0];
    logic signed [DW-1:0] work_re_d [N-1:0];
    logic signed [DW-1:0] work_im_q [N-1:0];
    logic signed [DW-1:0] work_im_d [N-1:0];
    logic signed [DW-1:0] out_re_q  [N-1:0];
    logic signed [DW-1:0] out_re_d  [N-1:0];
    logic signed [DW-1:0] out_im_q  [N-1:0];
    logic signed [DW-1:0] out_im_d  [N-1:0];
    logic signed [TW-1:0] cos_rom   [N/2-1:0];
    logic signed [TW-1:0] sin_rom   [N/2-1:0];
    logic [LOG2N-1:0]     mask, lo, top, bot;
    logic [KW-1:0]        k;
    logic signed [DW-1:0] x_re, x_im, y_re, y_im;
    logic                 bf_ovf, load, comp, fin;

    assign load     = state_q == LOAD;
    assign comp     = state_q == COMPUTE;
    assign fin      = state_q == DONE;
    assign busy     = load || comp;
    assign done     = done_q;
    assign overflow = ovf_q;

    always_comb begin
        mask = ~({LOG2N{1'b1}} << stage_q);
        lo   = bfly_q & mask;
        top  = ((bfly_q >> stage_q) << (stage_q + 1'b1)) | lo;
        bot  = top | (LOG2N'(1) << stage_q);
        k    = KW'(lo << (SMAX - stage_q));
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        bfly_d  = bfly_q;
        inv_d   = inv_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: state_d = start ? LOAD : IDLE;
            LOAD: begin
                state_d = COMPUTE;
                stage_d = '0;
                bfly_d  = '0;
                inv_d   = inverse;
                ovf_d   = 1'b0;
            end
            COMPUTE: begin
                ovf_d  = ovf_q | bf_ovf;
                bfly_d = bfly_q + 1'b1;
                if (bfly_q == BLAST) begin
                    bfly_d  = '0;
                    stage_d = stage_q + 1'b1;
                    state_d = stage_q == SMAX ? DONE : COMPUTE;
                end
            end
            default: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            stage_q <= '0;
            bfly_q  <= '0;
            inv_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            bfly_q  <= bfly_d;
            inv_q   <= inv_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    for (genvar i = 0; i < N / 2; i++) begin : g_rom
        localparam int C = twiddle(i, N, TW, 1'b0);
        localparam int S = twiddle(i, N, TW, 1'b1);
        assign cos_rom[i] = TW'(C);
        assign sin_rom[i] = TW'(S);
    end

    fft_butterfly #(.DW(DW), .TW(TW), .SCALE_EN(SCALE_EN)) u_bfly (
        .a_re    (work_re_q[top]),
        .a_im    (work_im_q[top]),
        .b_re    (work_re_q[bot]),
        .b_im    (work_im_q[bot]),
        .w_cos   (cos_rom[k]),
        .w_sin   (sin_rom[k]),
        .inverse (inv_q),
        .x_re    (x_re),
        .x_im    (x_im),
        .y_re    (y_re),
        .y_im    (y_im),
        .ovf     (bf_ovf)
    );

    // bitrev is an involution, so loading work[i] from input[bitrev(i)] is the same permutation.
    for (genvar i = 0; i < N; i++) begin : g_cell
        localparam int               R = bitrev(i, LOG2N);
        localparam logic [LOG2N-1:0] I = LOG2N'(i);
        assign work_re_d[i] = load ? input_Re[R] : (comp && top == I) ? x_re :
                              (comp && bot == I) ? y_re : work_re_q[i];
        assign work_im_d[i] = load ? input_Im[R] : (comp && top == I) ? x_im :
                              (comp && bot == I) ? y_im : work_im_q[i];
        assign out_re_d[i]  = fin ? work_re_q[i] : out_re_q[i];
        assign out_im_d[i]  = fin ? work_im_q[i] : out_im_q[i];
        assign output_Re[i] = out_re_q[i];
        assign output_Im[i] = out_im_q[i];
        always_ff @(posedge clk) begin
            if (!rst) begin
                work_re_q[i] <= '0;
                work_im_q[i] <= '0;
                out_re_q[i]  <= '0;
                out_im_q[i]  <= '0;
            end else begin
                work_re_q[i] <= work_re_d[i];
                work_im_q[i] <= work_im_d[i];
                out_re_q[i]  <= out_re_d[i];
                out_im_q[i]  <= out_im_d[i];
            end
        end
    end
endmodule
